// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit between execute and a byte-writable data RAM
// Splits unaligned stores into byte writes, stitches two-word loads, extends load data.
module lsu_align #(
  parameter logic [31:0] BASE  = 32'h0001_0000,
  parameter logic [31:0] LIMIT = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_alucode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic [5:0]  ram_alucode,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic [31:0] ram_r_addr,
  input  logic [31:0] ram_r_data
);
  localparam logic [5:0] ALU_NOP = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd1;
  localparam logic [5:0] ALU_LH  = 6'd2;
  localparam logic [5:0] ALU_LW  = 6'd3;
  localparam logic [5:0] ALU_LBU = 6'd4;
  localparam logic [5:0] ALU_LHU = 6'd5;
  localparam logic [5:0] ALU_SB  = 6'd6;
  localparam logic [5:0] ALU_SH  = 6'd7;
  localparam logic [5:0] ALU_SW  = 6'd8;

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_STB, S_RESP} state_t;

  function automatic logic [2:0] op_size(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: op_size = 3'd1;
      ALU_LH, ALU_LHU, ALU_SH: op_size = 3'd2;
      ALU_LW, ALU_SW:          op_size = 3'd4;
      default:                 op_size = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    is_load = (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
              (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

  function automatic logic spans(input logic [5:0] op, input logic [1:0] off);
    spans = (((op == ALU_LH) || (op == ALU_LHU)) && (off == 2'd3)) ||
            ((op == ALU_LW) && (off != 2'd0));
  endfunction

  function automatic logic is_split(input logic [5:0] op, input logic [1:0] off);
    is_split = ((op == ALU_SH) && (off == 2'd3)) || ((op == ALU_SW) && (off != 2'd0));
  endfunction

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] off,
                                          input logic [63:0] w);
    logic [31:0] v;
    v = 32'(w >> {off, 3'b000});
    case (op)
      ALU_LB:  extract = {{24{v[7]}}, v[7:0]};
      ALU_LH:  extract = {{16{v[15]}}, v[15:0]};
      ALU_LBU: extract = {24'b0, v[7:0]};
      ALU_LHU: extract = {16'b0, v[15:0]};
      default: extract = v;
    endcase
  endfunction

  state_t      state_q;
  logic [1:0]  k_q;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] w0_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        resp_fault_q;
  logic [5:0]  ram_alucode_q;
  logic [31:0] ram_w_addr_q;
  logic [31:0] ram_w_data_q;
  logic [31:0] ram_r_addr_q;

  // 33-bit last-byte address so a request near 0xFFFFFFFF cannot wrap into the window
  logic [32:0] last_byte;
  logic        req_fault;
  always_comb begin
    last_byte = {1'b0, req_addr} + {30'b0, op_size(req_alucode)} - 33'd1;
    req_fault = (op_size(req_alucode) == 3'd0) || (req_addr < BASE) ||
                (last_byte >= {1'b0, LIMIT});
  end

  logic [1:0] off;
  logic [1:0] last_k;
  logic [1:0] k_d;
  assign off    = addr_q[1:0];
  assign last_k = (op_q == ALU_SH) ? 2'd1 : 2'd3;
  assign k_d    = k_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= 2'd0;
      op_q          <= ALU_NOP;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      rd_q          <= 5'd0;
      w0_q          <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_rd_q     <= 5'd0;
      resp_fault_q  <= 1'b0;
      ram_alucode_q <= ALU_NOP;
      ram_w_addr_q  <= 32'd0;
      ram_w_data_q  <= 32'd0;
      ram_r_addr_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_alucode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            k_q     <= 2'd0;
            if (req_fault) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'd0;
              resp_rd_q    <= req_rd;
              resp_fault_q <= 1'b1;
            end else begin
              state_q      <= S_ACC0;
              ram_r_addr_q <= {req_addr[31:2], 2'b00};
              // Direct stores present their write during ACC0, so load the port now.
              if (!is_load(req_alucode) && !is_split(req_alucode, req_addr[1:0])) begin
                ram_alucode_q <= req_alucode;
                ram_w_addr_q  <= req_addr;
                ram_w_data_q  <= req_wdata;
              end
            end
          end
        end
        S_ACC0: begin
          ram_alucode_q <= ALU_NOP;
          if (is_load(op_q)) begin
            w0_q <= ram_r_data;
            if (spans(op_q, off)) begin
              ram_r_addr_q <= ram_r_addr_q + 32'd4;
              state_q      <= S_ACC1;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= extract(op_q, off, {32'b0, ram_r_data});
              resp_rd_q    <= rd_q;
              resp_fault_q <= 1'b0;
            end
          end else if (is_split(op_q, off)) begin
            state_q       <= S_STB;
            ram_alucode_q <= ALU_SB;
            ram_w_addr_q  <= addr_q;
            ram_w_data_q  <= {24'b0, wdata_q[7:0]};
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'd0;
            resp_rd_q    <= rd_q;
            resp_fault_q <= 1'b0;
          end
        end
        S_ACC1: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= extract(op_q, off, {ram_r_data, w0_q});
          resp_rd_q    <= rd_q;
          resp_fault_q <= 1'b0;
        end
        S_STB: begin
          if (k_q == last_k) begin
            ram_alucode_q <= ALU_NOP;
            state_q       <= S_RESP;
            resp_valid_q  <= 1'b1;
            resp_rdata_q  <= 32'd0;
            resp_rd_q     <= rd_q;
            resp_fault_q  <= 1'b0;
          end else begin
            k_q          <= k_d;
            ram_w_addr_q <= addr_q + {30'b0, k_d};
            ram_w_data_q <= {24'b0, wdata_q[{k_d, 3'b000} +: 8]};
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gating with rst_n stops a pending byte store from committing on the reset edge.
  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign ram_alucode = rst_n ? ram_alucode_q : ALU_NOP;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_rd     = resp_rd_q;
  assign resp_fault  = resp_fault_q;
  assign ram_w_addr  = ram_w_addr_q;
  assign ram_w_data  = ram_w_data_q;
  assign ram_r_addr  = ram_r_addr_q;
endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - self-checking bench for lsu_align with a byte RAM model and scoreboard
module tb_lsu_align;
  localparam logic [5:0] ALU_NOP = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd1;
  localparam logic [5:0] ALU_LH  = 6'd2;
  localparam logic [5:0] ALU_LW  = 6'd3;
  localparam logic [5:0] ALU_LBU = 6'd4;
  localparam logic [5:0] ALU_LHU = 6'd5;
  localparam logic [5:0] ALU_SB  = 6'd6;
  localparam logic [5:0] ALU_SH  = 6'd7;
  localparam logic [5:0] ALU_SW  = 6'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_alucode = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [5:0]  ram_alucode;
  logic [31:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic [31:0] ram_r_addr;
  logic [31:0] ram_r_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lsu_align #(.BASE(32'h0001_0000), .LIMIT(32'h0002_0000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_alucode(req_alucode), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault),
    .ram_alucode(ram_alucode), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] code; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] rdata; logic fault; int cyc; } exp_t;
  wr_t  wr_log[$];
  exp_t sb[$];

  // RAM model: 64 KiB window, combinational read, write on rising edge
  bit [7:0] ram [0:65535];
  logic [15:0] ridx;
  always_comb begin
    ridx = {ram_r_addr[15:2], 2'b00};
    ram_r_data = 32'd0;
    if (ram_r_addr[31:16] == 16'h0001)
      ram_r_data = {ram[ridx + 16'd3], ram[ridx + 16'd2], ram[ridx + 16'd1], ram[ridx]};
  end

  always @(posedge clk) begin
    if (ram_alucode == ALU_SB || ram_alucode == ALU_SH || ram_alucode == ALU_SW)
      wr_log.push_back('{ram_alucode, ram_w_addr, ram_w_data});
    case (ram_alucode)
      ALU_SB: ram[ram_w_addr[15:0]] <= ram_w_data[7:0];
      ALU_SH: begin
        ram[ram_w_addr[15:0]]         <= ram_w_data[7:0];
        ram[ram_w_addr[15:0] + 16'd1] <= ram_w_data[15:8];
      end
      ALU_SW: begin
        ram[ram_w_addr[15:0]]         <= ram_w_data[7:0];
        ram[ram_w_addr[15:0] + 16'd1] <= ram_w_data[15:8];
        ram[ram_w_addr[15:0] + 16'd2] <= ram_w_data[23:16];
        ram[ram_w_addr[15:0] + 16'd3] <= ram_w_data[31:24];
      end
      default: ;
    endcase
  end

  // Response monitor: pops the scoreboard on every resp_valid
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: resp_valid=1 rd=%0d with no request outstanding", resp_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 4;
        if (resp_rdata !== e.rdata) begin
          errors++; $display("FAIL resp_rdata rd=%0d: got %h expected %h", e.rd, resp_rdata, e.rdata);
        end
        if (resp_rd !== e.rd) begin
          errors++; $display("FAIL resp_rd: got %0d expected %0d", resp_rd, e.rd);
        end
        if (resp_fault !== e.fault) begin
          errors++; $display("FAIL resp_fault rd=%0d: got %0b expected %0b", e.rd, resp_fault, e.fault);
        end
        if (cyc !== e.cyc) begin
          errors++; $display("FAIL resp_latency rd=%0d: resp at cycle %0d expected %0d", e.rd, cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] exp_rdata, input logic exp_fault,
                       input int lat, input bit expect_resp, output int acc);
    int n;
    n = 0;
    acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_alucode = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept rd=%0d: req_ready=%0b after %0d cycles, expected 1", rd, req_ready, n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc = cyc;
      if (expect_resp) sb.push_back('{rd, exp_rdata, exp_fault, cyc + lat - 1});
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [4:0] rd, input logic [31:0] exp_rdata, input logic exp_fault,
                     input int lat);
    int acc;
    issue(op, addr, wdata, rd, exp_rdata, exp_fault, lat, 1'b1, acc);
    wait_drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", req_ready); end
    if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL reset_resp: valid=%0b fault=%0b expected 0 0", resp_valid, resp_fault);
    end
    if (resp_rdata !== 32'd0 || resp_rd !== 5'd0) begin
      errors++; $display("FAIL reset_resp_data: rdata=%h rd=%0d expected 0 0", resp_rdata, resp_rd);
    end
    if (ram_alucode !== ALU_NOP) begin errors++; $display("FAIL reset_alucode: got %0d expected 0", ram_alucode); end
    if (ram_w_addr !== 32'd0 || ram_w_data !== 32'd0 || ram_r_addr !== 32'd0) begin
      errors++; $display("FAIL reset_ram_port: w_addr=%h w_data=%h r_addr=%h expected 0", ram_w_addr, ram_w_data, ram_r_addr);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b expected 1", req_ready); end
  endtask

  task automatic test_aligned();
    req(ALU_SW, 32'h10004, 32'hDEADBEEF, 5'd4, 32'd0, 1'b0, 2);
    req(ALU_LW, 32'h10004, 32'd0, 5'd5, 32'hDEADBEEF, 1'b0, 2);
  endtask

  task automatic test_extend();
    req(ALU_SW,  32'h10004, 32'h80FF0000, 5'd6, 32'd0, 1'b0, 2);
    req(ALU_LB,  32'h10007, 32'd0, 5'd7, 32'hFFFFFF80, 1'b0, 2);
    req(ALU_LBU, 32'h10007, 32'd0, 5'd8, 32'h00000080, 1'b0, 2);
    req(ALU_LH,  32'h10006, 32'd0, 5'd9, 32'hFFFF80FF, 1'b0, 2);
    req(ALU_LHU, 32'h10006, 32'd0, 5'd10, 32'h000080FF, 1'b0, 2);
  endtask

  task automatic test_spanning();
    int acc;
    req(ALU_SW, 32'h10000, 32'h44332211, 5'd11, 32'd0, 1'b0, 2);
    req(ALU_SW, 32'h10004, 32'h88776655, 5'd12, 32'd0, 1'b0, 2);
    issue(ALU_LW, 32'h10002, 32'd0, 5'd13, 32'h66554433, 1'b0, 3, 1'b1, acc);
    @(negedge clk);
    checks++;
    if (ram_r_addr !== 32'h10000) begin errors++; $display("FAIL span_raddr0: got %h expected 00010000", ram_r_addr); end
    @(negedge clk);
    checks++;
    if (ram_r_addr !== 32'h10004) begin errors++; $display("FAIL span_raddr1: got %h expected 00010004", ram_r_addr); end
    wait_drain();
    req(ALU_LHU, 32'h10003, 32'd0, 5'd14, 32'h00005544, 1'b0, 3);
  endtask

  task automatic test_split_sw();
    logic [7:0] eb [4];
    eb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    wr_log.delete();
    req(ALU_SW, 32'h10001, 32'hAABBCCDD, 5'd15, 32'd0, 1'b0, 6);
    checks++;
    if (wr_log.size() != 4) begin
      errors++; $display("FAIL split_sw_count: got %0d writes expected 4", wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_log[i].code !== ALU_SB || wr_log[i].addr !== 32'h10001 + 32'(i) || wr_log[i].data !== {24'b0, eb[i]}) begin
          errors++;
          $display("FAIL split_sw_byte%0d: code=%0d addr=%h data=%h expected %0d %h %h",
                   i, wr_log[i].code, wr_log[i].addr, wr_log[i].data, ALU_SB, 32'h10001 + 32'(i), {24'b0, eb[i]});
        end
      end
    end
    req(ALU_LW, 32'h10000, 32'd0, 5'd16, 32'hBBCCDD11, 1'b0, 2);
    req(ALU_LW, 32'h10004, 32'd0, 5'd17, 32'h887766AA, 1'b0, 2);
  endtask

  task automatic test_sh();
    wr_log.delete();
    req(ALU_SH, 32'h10003, 32'h00001234, 5'd18, 32'd0, 1'b0, 4);
    checks++;
    if (wr_log.size() != 2 || wr_log[0].code !== ALU_SB || wr_log[0].addr !== 32'h10003 ||
        wr_log[0].data !== 32'h34 || wr_log[1].code !== ALU_SB || wr_log[1].addr !== 32'h10004 ||
        wr_log[1].data !== 32'h12) begin
      errors++; $display("FAIL split_sh: %0d writes, first addr=%h data=%h expected 2 writes 00010003/34 00010004/12",
                         wr_log.size(), wr_log.size() > 0 ? wr_log[0].addr : 32'd0, wr_log.size() > 0 ? wr_log[0].data : 32'd0);
    end
    wr_log.delete();
    req(ALU_SH, 32'h10002, 32'hFFFF1234, 5'd19, 32'd0, 1'b0, 2);
    checks++;
    if (wr_log.size() != 1 || wr_log[0].code !== ALU_SH || wr_log[0].addr !== 32'h10002 || wr_log[0].data[15:0] !== 16'h1234) begin
      errors++; $display("FAIL direct_sh: %0d writes, code=%0d addr=%h expected 1 write SH at 00010002 data 1234",
                         wr_log.size(), wr_log.size() > 0 ? wr_log[0].code : 6'd0, wr_log.size() > 0 ? wr_log[0].addr : 32'd0);
    end
    req(ALU_LW, 32'h10000, 32'd0, 5'd20, 32'h1234DD11, 1'b0, 2);
  endtask

  task automatic test_boundary();
    req(ALU_SB,  32'h1FFFF, 32'h000000C3, 5'd21, 32'd0, 1'b0, 2);
    req(ALU_LB,  32'h1FFFF, 32'd0, 5'd22, 32'hFFFFFFC3, 1'b0, 2);
    req(ALU_LBU, 32'h1FFFF, 32'd0, 5'd23, 32'h000000C3, 1'b0, 2);
    req(ALU_LH,  32'h1FFFF, 32'd0, 5'd24, 32'd0, 1'b1, 1);
  endtask

  task automatic test_faults();
    wr_log.delete();
    req(ALU_LW, 32'h0FFFC, 32'd0, 5'd25, 32'd0, 1'b1, 1);
    req(ALU_SW, 32'h1FFFD, 32'h01020304, 5'd26, 32'd0, 1'b1, 1);
    req(6'd42,  32'h10000, 32'h01020304, 5'd27, 32'd0, 1'b1, 1);
    checks++;
    if (wr_log.size() != 0) begin
      errors++; $display("FAIL fault_no_write: got %0d writes expected 0", wr_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int a1;
    issue(ALU_LW, 32'h10000, 32'd0, 5'd28, 32'h1234DD11, 1'b0, 2, 1'b1, a0);
    issue(ALU_LW, 32'h10004, 32'd0, 5'd29, 32'h88776612, 1'b0, 2, 1'b1, a1);
    wait_drain();
    checks++;
    if (a1 - a0 != 3) begin errors++; $display("FAIL b2b_spacing: accept gap %0d cycles expected 3", a1 - a0); end
  endtask

  task automatic test_reset_in_stb();
    int acc;
    int n;
    wr_log.delete();
    issue(ALU_SW, 32'h10011, 32'h11223344, 5'd30, 32'd0, 1'b0, 0, 1'b0, acc);
    n = 0;
    while (wr_log.size() < 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (wr_log.size() != 2 || wr_log[0].addr !== 32'h10011 || wr_log[0].data !== 32'h44 ||
        wr_log[1].addr !== 32'h10012 || wr_log[1].data !== 32'h33) begin
      errors++; $display("FAIL stb_reset_writes: %0d writes expected 2 (00010011/44 00010012/33)", wr_log.size());
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL stb_reset_idle: req_ready=%0b expected 1", req_ready); end
    req(ALU_LW, 32'h10010, 32'd0, 5'd31, 32'h00334400, 1'b0, 2);
    req(ALU_LW, 32'h10014, 32'd0, 5'd1, 32'h00000000, 1'b0, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_extend();
    test_spanning();
    test_split_sw();
    test_sh();
    test_boundary();
    test_faults();
    test_back_to_back();
    test_reset_in_stb();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
